seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_pkg.sv | 27 ++
 rtl/seg_scan_driver_bcd_to_seg.sv | 11 +
 rtl/seg_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the multiplexed six-digit seven-segment scanner:
// FSM encoding, digit slot indices and the BCD-to-segment table.
package seg_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] IDX_SEC_L = 3'd0;
    localparam logic [2:0] IDX_SEC_H = 3'd1;
    localparam logic [2:0] IDX_MIN_L = 3'd2;
    localparam logic [2:0] IDX_MIN_H = 3'd3;
    localparam logic [2:0] IDX_HR_L  = 3'd4;
    localparam logic [2:0] IDX_HR_H  = 3'd5;

    // Segments g..a, active-high; entry 0 sits in the low bits, 10..15 show '-'.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Purely combinational BCD digit to logical a..g segment pattern.
module bcd_to_seg
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a six-digit hh.mm.ss display with a per-slot
// select guard, frame snapshot of the digits and registered, glitch-free outputs.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 100,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int BLANK_LEAD     = 1
) (
    input  logic       Clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] hr_h,
    input  logic [3:0] hr_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] sec_l,
    output logic [7:0] seg,
    output logic [5:0] sel,
    output logic       frame_done
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
    localparam logic [7:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [5:0]       SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0] snap_q, snap_d;
    logic [7:0]                seg_q, seg_d;
    logic [5:0]                sel_q, sel_d;
    logic                      frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0][3:0] digits_in;
    logic [NUM_DIGITS-1:0]      sel_onehot;
    logic [3:0]                 digit_cur;
    logic [6:0]                 seg_raw;
    logic                       blank;
    logic [7:0]                 seg_logic;
    logic [5:0]                 sel_logic;

    assign digits_in = {hr_h, hr_l, min_h, min_l, sec_h, sec_l};

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign sel_onehot[gi] = (idx_q == 3'(gi));
    end

    always_comb begin
        digit_cur = 4'd0;
        case (idx_q)
            IDX_SEC_L: digit_cur = snap_q[0];
            IDX_SEC_H: digit_cur = snap_q[1];
            IDX_MIN_L: digit_cur = snap_q[2];
            IDX_MIN_H: digit_cur = snap_q[3];
            IDX_HR_L:  digit_cur = snap_q[4];
            IDX_HR_H:  digit_cur = snap_q[5];
            default:   digit_cur = 4'd0;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (digit_cur),
        .seg (seg_raw)
    );

    // Next state: the snapshot is refreshed whenever slot 0 is entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = IDX_SEC_L;
        end else if (state_q == ST_IDLE) begin
            cnt_d   = '0;
            idx_d   = IDX_SEC_L;
            snap_d  = digits_in;
            state_d = (cnt_d < GUARD_C) ? ST_GUARD : ST_SHOW;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (idx_q == IDX_HR_H) begin
                    idx_d  = IDX_SEC_L;
                    snap_d = digits_in;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            state_d = (cnt_d < GUARD_C) ? ST_GUARD : ST_SHOW;
        end
    end

    // Output image of the current state; inverted only on its way into the register.
    always_comb begin
        seg_logic = 8'h00;
        sel_logic = 6'h00;
        blank     = (BLANK_LEAD != 0) && (idx_q == IDX_HR_H) && (digit_cur == 4'd0);
        if (state_q != ST_IDLE) begin
            seg_logic[6:0] = blank ? 7'h00 : seg_raw;
            seg_logic[7]   = (idx_q == IDX_MIN_L) || (idx_q == IDX_HR_L);
            if (state_q == ST_SHOW) begin
                sel_logic = sel_onehot;
            end
        end
        seg_d        = (SEG_ACTIVE_LOW != 0) ? ~seg_logic : seg_logic;
        sel_d        = (SEL_ACTIVE_LOW != 0) ? ~sel_logic : sel_logic;
        frame_done_d = (state_q != ST_IDLE) && (idx_q == IDX_HR_H) && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= IDX_SEC_L;
            snap_q       <= '0;
            seg_q        <= SEG_OFF;
            sel_q        <= SEL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-position model checked every cycle, plus
// directed literal checks at hand-computed cycle offsets.
module tb_seg_scan_driver;

    localparam int D = 4;
    localparam int G = 1;
    localparam int FRAME = 6 * D;

    logic       Clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] hr_h = 4'd1, hr_l = 4'd2, min_h = 4'd3, min_l = 4'd4, sec_h = 4'd5, sec_l = 4'd6;
    logic [7:0] seg;
    logic [5:0] sel;
    logic       frame_done;

    int n_checks = 0;
    int n_err    = 0;
    int since    = 0;
    bit chk_on   = 1'b0;

    seg_scan_driver #(
        .SCAN_DIV       (D),
        .GUARD          (G),
        .SEG_ACTIVE_LOW (0),
        .SEL_ACTIVE_LOW (0),
        .BLANK_LEAD     (1)
    ) dut (
        .Clk        (Clk),
        .rst_n      (rst_n),
        .en         (en),
        .hr_h       (hr_h),
        .hr_l       (hr_l),
        .min_h      (min_h),
        .min_l      (min_l),
        .sec_h      (sec_h),
        .sec_l      (sec_l),
        .seg        (seg),
        .sel        (sel),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    // Model: a single position within the frame plus the captured digits.
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [3:0] m_snap [6] = '{default: 4'd0};
    logic [7:0] exp_seg = 8'h00;
    logic [5:0] exp_sel = 6'h00;
    logic       exp_fd = 1'b0;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [7:0] slot_pattern(input int slot, input logic [3:0] v);
        logic [7:0] p;
        p[6:0] = (slot == 5 && v == 4'd0) ? 7'h00 : glyph(v);
        p[7]   = (slot == 2 || slot == 4);
        return p;
    endfunction

    always @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_pos    <= 0;
            m_snap   <= '{default: 4'd0};
            exp_seg  <= 8'h00;
            exp_sel  <= 6'h00;
            exp_fd   <= 1'b0;
        end else begin
            if (m_active) begin
                exp_seg <= slot_pattern(m_pos / D, m_snap[m_pos / D]);
                exp_sel <= ((m_pos % D) < G) ? 6'h00 : 6'(1 << (m_pos / D));
                exp_fd  <= (m_pos == FRAME - 1);
            end else begin
                exp_seg <= 8'h00;
                exp_sel <= 6'h00;
                exp_fd  <= 1'b0;
            end
            if (!en) begin
                m_active <= 1'b0;
                m_pos    <= 0;
            end else if (!m_active || m_pos == FRAME - 1) begin
                m_active <= 1'b1;
                m_pos    <= 0;
                m_snap   <= '{sec_l, sec_h, min_l, min_h, hr_l, hr_h};
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_on) begin
            check("model_seg", seg, exp_seg);
            check("model_sel", {2'b00, sel}, {2'b00, exp_sel});
            check("model_fd", {7'd0, frame_done}, {7'd0, exp_fd});
        end
    end

    task automatic adv(input int n);
        while (since < n) begin
            @(negedge Clk);
            since++;
        end
    endtask

    task automatic lit(input string name, input int at, input logic [7:0] s, input logic [5:0] q);
        adv(at);
        check({name, "_seg"}, seg, s);
        check({name, "_sel"}, {2'b00, sel}, {2'b00, q});
        $display("check %s at cycle %0d: seg=%02h sel=%02h", name, at, seg, sel);
    endtask

    task automatic lit_fd(input string name, input int at, input logic f);
        adv(at);
        check(name, {7'd0, frame_done}, {7'd0, f});
        $display("check %s at cycle %0d: frame_done=%0b", name, at, frame_done);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk_on = 1'b1;
        check("reset_seg", seg, 8'h00);
        check("reset_sel", {2'b00, sel}, 8'h00);
        check("reset_fd", {7'd0, frame_done}, 8'h00);
        @(negedge Clk);
        rst_n = 1'b1;
        en    = 1'b1;
        since = 0;

        // Frame 1 and 2 with 12:34:56
        lit("sec_l_guard", 2, 8'h7D, 6'h00);
        lit("sec_l_show", 3, 8'h7D, 6'h01);
        lit("sec_l_last", 5, 8'h7D, 6'h01);
        lit("sec_h_guard", 6, 8'h6D, 6'h00);
        lit("min_l_dp", 11, 8'hE6, 6'h04);
        lit("hr_l_dp", 19, 8'hDB, 6'h10);
        lit("hr_h_one", 23, 8'h06, 6'h20);
        lit_fd("fd_idle_before", 24, 1'b0);
        lit_fd("fd_frame1", 25, 1'b1);
        lit_fd("fd_after", 26, 1'b0);
        lit_fd("fd_frame2", 49, 1'b1);

        // 00:00:00 captured at the start of frame 4
        {hr_h, hr_l, min_h, min_l, sec_h, sec_l} = '0;
        lit("zero_sec_l", 74, 8'h3F, 6'h00);
        lit("zero_min_l", 83, 8'hBF, 6'h04);
        lit("zero_hr_l", 91, 8'hBF, 6'h10);
        lit("zero_hr_h_blank", 95, 8'h00, 6'h20);

        adv(96);
        sec_l = 4'd5;
        lit("snap_sec_l5", 98, 8'h6D, 6'h00);
        lit("snap_sec_h", 102, 8'h3F, 6'h00);
        adv(110);
        sec_l = 4'd9;
        lit("midframe_hr_l", 115, 8'hBF, 6'h10);
        lit("next_frame_sec_l9", 122, 8'h6F, 6'h00);
        sec_l = 4'hC;
        lit("dash_sec_l", 146, 8'h40, 6'h00);
        lit("dash_sec_l_show", 147, 8'h40, 6'h01);

        // en drop while idx=2, cnt=2
        adv(155);
        en = 1'b0;
        lit("en_drop_hold", 156, 8'hBF, 6'h04);
        lit("en_drop_off", 157, 8'h00, 6'h00);
        for (int k = 158; k <= 165; k++) lit_fd("en_drop_no_fd", k, 1'b0);
        en    = 1'b1;
        since = 0;
        lit("reen_sec_l", 2, 8'h40, 6'h00);
        lit("reen_sec_l_show", 3, 8'h40, 6'h01);

        // Asynchronous reset in mid-frame
        adv(8);
        @(posedge Clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", seg, 8'h00);
        check("async_rst_sel", {2'b00, sel}, 8'h00);
        check("async_rst_fd", {7'd0, frame_done}, 8'h00);
        $display("check async_reset: seg=%02h sel=%02h frame_done=%0b", seg, sel, frame_done);
        @(negedge Clk);
        @(negedge Clk);
        rst_n = 1'b1;
        since = 0;
        lit("rst_restart_sec_l", 2, 8'h40, 6'h00);
        lit("rst_restart_show", 3, 8'h40, 6'h01);
        lit_fd("rst_fd_pre", 24, 1'b0);
        lit_fd("rst_fd", 25, 1'b1);
        adv(30);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
